// File: rtl/local_packet_sender.sv
`default_nettype none
// ============================================================================
//  Module      : local_packet_sender
//  Description : Host-side packet source for a router local port. Payload
//                flits are buffered in a show-ahead FIFO; a send request
//                emits a header flit (target), a size flit (length) and then
//                the requested number of payload flits under credit flow
//                control.
//  Revision    : 1.0 - initial release
// ============================================================================
module local_packet_sender #(
    parameter int TAM_FLIT = 16,
    parameter int DEPTH    = 8,
    parameter int LEN_W    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    // host payload interface
    input  logic                       host_wr,
    input  logic [TAM_FLIT-1:0]        host_data,
    output logic                       host_full,
    output logic [$clog2(DEPTH):0]     host_count,
    // host command interface
    input  logic                       send_req,
    input  logic [TAM_FLIT-1:0]        send_target,
    input  logic [LEN_W-1:0]           send_len,
    output logic                       send_busy,
    output logic                       send_done,
    output logic                       send_err,
    // router local port
    output logic                       tx,
    output logic [TAM_FLIT-1:0]        data_out,
    input  logic                       credit_i,
    output logic                       clock_tx
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    // payload FIFO storage and bookkeeping
    logic [TAM_FLIT-1:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    // latched packet context
    logic [TAM_FLIT-1:0]   target_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;

    logic                  done_q;
    logic                  err_q;

    logic                  fifo_empty;
    logic                  wr_en;
    logic                  pop;
    logic                  link_fire;
    logic                  send_accept;
    logic                  send_reject;
    logic                  last_flit;

    assign fifo_empty  = (count == '0);
    assign host_full   = (count == FULL_COUNT);
    assign host_count  = count;

    // A write is taken only when there is room at the edge; a pop in the
    // same cycle does not free space for a write that sees the FIFO full.
    assign wr_en       = host_wr & ~host_full;

    assign link_fire   = tx & credit_i;
    assign pop         = (state == PAYLOAD) & link_fire;
    assign last_flit   = (remaining == LEN_W'(1));

    // Requests are only looked at in IDLE; a zero length is rejected there.
    assign send_accept = (state == IDLE) & send_req & (send_len != '0);
    assign send_reject = (state == IDLE) & send_req & (send_len == '0);

    assign send_busy   = (state != IDLE);
    assign send_done   = done_q;
    assign send_err    = err_q;

    // Forwarded clock toward the router, purely combinational.
    assign clock_tx    = clock;

    // Payload storage: no reset needed, occupancy tracking makes stale data invisible.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= host_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Packet context: capture on acceptance, count down on each payload transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            target_q  <= '0;
            len_q     <= '0;
            remaining <= '0;
        end else if (send_accept) begin
            target_q  <= send_target;
            len_q     <= send_len;
            remaining <= send_len;
        end else if (pop) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Status pulses, each one cycle after the event that causes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= pop & last_flit;
            err_q  <= send_reject;
        end
    end

    // Next-state and link outputs; data_out is a pure function of state so
    // it holds automatically while a flit waits for credit.
    always_comb begin
        state_next = state;
        tx         = 1'b0;
        data_out   = '0;
        case (state)
            IDLE: begin
                if (send_accept) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                tx       = 1'b1;
                data_out = target_q;
                if (credit_i) begin
                    state_next = SIZE;
                end
            end
            SIZE: begin
                tx       = 1'b1;
                data_out = TAM_FLIT'(len_q);
                if (credit_i) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx       = ~fifo_empty;
                data_out = mem[rd_ptr];
                if (pop && last_flit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_local_packet_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_local_packet_sender
//  Description : Self-checking bench for local_packet_sender. The stimulus
//                process records accepted writes and packets in queues; the
//                monitor replays the link protocol from those queues and
//                compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_local_packet_sender;

    localparam int TAM_FLIT = 16;
    localparam int DEPTH    = 8;
    localparam int LEN_W    = 8;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  host_wr;
    logic [TAM_FLIT-1:0]   host_data;
    logic                  host_full;
    logic [CW-1:0]         host_count;
    logic                  send_req;
    logic [TAM_FLIT-1:0]   send_target;
    logic [LEN_W-1:0]      send_len;
    logic                  send_busy;
    logic                  send_done;
    logic                  send_err;
    logic                  tx;
    logic [TAM_FLIT-1:0]   data_out;
    logic                  credit_i;
    logic                  clock_tx;

    always #5 clock = ~clock;

    local_packet_sender #(
        .TAM_FLIT (TAM_FLIT),
        .DEPTH    (DEPTH),
        .LEN_W    (LEN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .host_wr     (host_wr),
        .host_data   (host_data),
        .host_full   (host_full),
        .host_count  (host_count),
        .send_req    (send_req),
        .send_target (send_target),
        .send_len    (send_len),
        .send_busy   (send_busy),
        .send_done   (send_done),
        .send_err    (send_err),
        .tx          (tx),
        .data_out    (data_out),
        .credit_i    (credit_i),
        .clock_tx    (clock_tx)
    );

    typedef struct {
        logic [TAM_FLIT-1:0] target;
        int                  len;
    } pkt_t;

    // Reference model: accepted packets and the payload flits still owed to the link.
    pkt_t                pkt_q[$];
    logic [TAM_FLIT-1:0] payload_q[$];
    bit                  m_busy     = 1'b0;
    int                  m_pos      = 0;
    bit                  exp_done   = 1'b0;
    bit                  exp_err    = 1'b0;
    bit                  prev_reset = 1'b0;

    // Per-cycle acceptance decided by the stimulus side
    bit                  wr_acc  = 1'b0;
    bit                  req_acc = 1'b0;
    bit                  req_err = 1'b0;

    int                  vectors     = 0;
    int                  miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic drive(input bit rst, input bit wr, input logic [TAM_FLIT-1:0] d,
                         input bit req, input logic [TAM_FLIT-1:0] tgt,
                         input logic [LEN_W-1:0] len, input bit cr);
        pkt_t p;
        @(posedge clock);
        #1;
        reset       = rst;
        host_wr     = wr;
        host_data   = d;
        send_req    = req;
        send_target = tgt;
        send_len    = len;
        credit_i    = cr;
        wr_acc  = !rst && wr && (payload_q.size() < DEPTH);
        req_acc = !rst && req && !m_busy && (len != '0);
        req_err = !rst && req && !m_busy && (len == '0);
        if (wr_acc) payload_q.push_back(d);
        if (req_acc) begin
            p.target = tgt;
            p.len    = int'(len);
            pkt_q.push_back(p);
        end
    endtask

    task automatic idle_cycle(input bit cr);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, cr);
    endtask

    task automatic write_flit(input logic [TAM_FLIT-1:0] d);
        drive(1'b0, 1'b1, d, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic request(input logic [TAM_FLIT-1:0] tgt, input logic [LEN_W-1:0] len, input bit wr);
        drive(1'b0, wr, TAM_FLIT'($urandom), 1'b1, tgt, len, 1'b1);
    endtask

    // Run with credit until the model says the packet is over; bounded.
    task automatic wait_idle(input bit fill);
        int i;
        drive(1'b0, fill, TAM_FLIT'($urandom), 1'b0, '0, '0, 1'b1);
        for (i = 0; i < 300 && m_busy; i++) begin
            drive(1'b0, fill, TAM_FLIT'($urandom), 1'b0, '0, '0, 1'b1);
        end
        if (m_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: packet still busy after %0d cycles, send_busy=%0b", i, send_busy);
        end
    endtask

    // Monitor: compares the DUT each mid-cycle against the model, then advances the model.
    always @(negedge clock) begin : monitor
        int                  eff;
        bit                  exp_tx;
        bit                  fire;
        logic [TAM_FLIT-1:0] exp_d;
        eff    = payload_q.size() - (wr_acc ? 1 : 0);
        exp_tx = m_busy && (m_pos < 2 || eff > 0);
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("send_busy", 32'(send_busy), 32'(m_busy));
        chk("send_done", 32'(send_done), 32'(exp_done));
        chk("send_err", 32'(send_err), 32'(exp_err));
        chk("host_count", 32'(host_count), 32'(eff));
        chk("host_full", 32'(host_full), 32'(eff == DEPTH));
        chk("clock_tx", 32'(clock_tx), 32'(clock));
        if (exp_tx) begin
            if (m_pos == 0)      exp_d = pkt_q[0].target;
            else if (m_pos == 1) exp_d = TAM_FLIT'(pkt_q[0].len);
            else                 exp_d = payload_q[0];
            chk("data_out", 32'(data_out), 32'(exp_d));
        end
        if (prev_reset) chk("data_out_after_reset", 32'(data_out), 32'h0);
        prev_reset = reset;
        fire = exp_tx && credit_i;
        if (reset) begin
            m_busy   = 1'b0;
            m_pos    = 0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            payload_q.delete();
            pkt_q.delete();
        end else begin
            exp_done = 1'b0;
            exp_err  = req_err;
            if (fire) begin
                if (m_pos >= 2) void'(payload_q.pop_front());
                if (m_pos == pkt_q[0].len + 1) begin
                    void'(pkt_q.pop_front());
                    m_busy   = 1'b0;
                    m_pos    = 0;
                    exp_done = 1'b1;
                end else begin
                    m_pos++;
                end
            end
            if (req_acc) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        host_wr     = 1'b0;
        host_data   = '0;
        send_req    = 1'b0;
        send_target = '0;
        send_len    = '0;
        credit_i    = 1'b0;
        repeat (3) drive(1'b1, 1'b1, 16'hDEAD, 1'b1, 16'h0022, 8'd2, 1'b1);

        // basic packet
        write_flit(16'hA001);
        write_flit(16'hA002);
        write_flit(16'hA003);
        request(16'h0011, 8'd3, 1'b0);
        wait_idle(1'b0);
        idle_cycle(1'b1);

        // credit stall during SIZE
        write_flit(16'hB001);
        write_flit(16'hB002);
        write_flit(16'hB003);
        request(16'h0011, 8'd3, 1'b0);
        idle_cycle(1'b1);
        repeat (4) idle_cycle(1'b0);
        wait_idle(1'b0);

        // starved payload
        request(16'h0033, 8'd2, 1'b0);
        repeat (6) idle_cycle(1'b1);
        write_flit(16'hC001);
        write_flit(16'hC002);
        wait_idle(1'b0);
        idle_cycle(1'b1);

        // overflow, then a write while full coinciding with a pop
        for (int i = 0; i < DEPTH + 1; i++) write_flit(16'hD000 + 16'(i));
        request(16'h0044, 8'd1, 1'b1);
        repeat (4) write_flit(16'hE000);
        wait_idle(1'b0);
        request(16'h0045, 8'(DEPTH), 1'b0);
        wait_idle(1'b0);

        // wrap-around through the FIFO
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) write_flit(16'h5000 + 16'(p * 16 + i));
            request(16'h0100 + 16'(p), 8'd5, 1'b0);
            wait_idle(1'b0);
        end

        // zero-length request
        request(16'h0066, 8'd0, 1'b0);
        repeat (3) idle_cycle(1'b1);

        // reset during PAYLOAD
        for (int i = 0; i < 4; i++) write_flit(16'hF000 + 16'(i));
        request(16'h0077, 8'd4, 1'b0);
        repeat (3) idle_cycle(1'b1);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1);
        repeat (3) idle_cycle(1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 399) == 0),
                  1'($urandom_range(0, 1)),
                  TAM_FLIT'($urandom),
                  ($urandom_range(0, 9) == 0),
                  TAM_FLIT'($urandom),
                  LEN_W'($urandom_range(0, 9)),
                  ($urandom_range(0, 3) != 0));
        end

        // drain any packet still in flight
        wait_idle(1'b1);
        repeat (2) idle_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
